// File: rtl/ptn_pkg.sv
// Shared definitions for the pattern sequence generator: pattern codes and the
// colour constants used by the pixel pipeline.
package ptn_pkg;

  typedef enum logic [1:0] {
    PTN_BARS = 2'd0,
    PTN_GRID = 2'd1,
    PTN_GRAD = 2'd2,
    PTN_BOX  = 2'd3
  } ptn_e;

  localparam logic [23:0] CLR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] CLR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CLR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] CLR_GREEN   = 24'h00FF00;
  localparam logic [23:0] CLR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] CLR_RED     = 24'hFF0000;
  localparam logic [23:0] CLR_BLUE    = 24'h0000FF;
  localparam logic [23:0] CLR_BLACK   = 24'h000000;
  localparam logic [23:0] CLR_BOX_BG  = 24'h000020;
  localparam logic [7:0]  GRAD_BLUE   = 8'h80;

  // Colour of bar idx, left to right across the active line
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] clr;
    case (idx)
      3'd0:    clr = CLR_WHITE;
      3'd1:    clr = CLR_YELLOW;
      3'd2:    clr = CLR_CYAN;
      3'd3:    clr = CLR_GREEN;
      3'd4:    clr = CLR_MAGENTA;
      3'd5:    clr = CLR_RED;
      3'd6:    clr = CLR_BLUE;
      3'd7:    clr = CLR_BLACK;
      default: clr = CLR_BLACK;
    endcase
    return clr;
  endfunction

endpackage

// File: rtl/ptn_box_mover.sv
// Bouncing-box position: moves one pixel per frame on each axis and reverses
// at the active-area edges, pausing for one frame on every bounce.
module ptn_box_mover
  import ptn_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic       FS,
  output logic [9:0] BOX_X,
  output logic [9:0] BOX_Y
);

  localparam logic [9:0] X_LIM = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_LIM = 10'(V_ACTIVE - BOX_SIZE);

  logic [9:0] x_r;
  logic [9:0] y_r;
  logic       dx_r;
  logic       dy_r;
  logic [9:0] x_nxt_s;
  logic [9:0] y_nxt_s;
  logic       dx_nxt_s;
  logic       dy_nxt_s;

  // One axis step: returns {forward, position} for the next frame
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic fwd,
                                            input logic [9:0] lim);
    logic [10:0] res;
    if (fwd) begin
      if (pos == lim) res = {1'b0, pos};
      else            res = {1'b1, pos + 10'd1};
    end else begin
      if (pos == 10'd0) res = {1'b1, pos};
      else              res = {1'b0, pos - 10'd1};
    end
    return res;
  endfunction

  // Next position; outputs show it during the FS pixel so frame 0,0 matches the rest of the frame
  always_comb begin
    {dx_nxt_s, x_nxt_s} = {dx_r, x_r};
    {dy_nxt_s, y_nxt_s} = {dy_r, y_r};
    if (FS) begin
      {dx_nxt_s, x_nxt_s} = axis_step(x_r, dx_r, X_LIM);
      {dy_nxt_s, y_nxt_s} = axis_step(y_r, dy_r, Y_LIM);
    end else begin
      {dx_nxt_s, x_nxt_s} = {dx_r, x_r};
      {dy_nxt_s, y_nxt_s} = {dy_r, y_r};
    end
  end

  // Position and direction registers
  always_ff @(posedge PCK) begin
    if (!RST) begin
      x_r  <= 10'd0;
      y_r  <= 10'd0;
      dx_r <= 1'b1;
      dy_r <= 1'b1;
    end else begin
      x_r  <= x_nxt_s;
      y_r  <= y_nxt_s;
      dx_r <= dx_nxt_s;
      dy_r <= dy_nxt_s;
    end
  end

  assign BOX_X = x_nxt_s;
  assign BOX_Y = y_nxt_s;

endmodule

// File: rtl/ptn_seq_gen.sv
// Multi-pattern video source: decodes one of four test patterns from syncgen
// counters and delays DE/syncs so RGB and timing leave together after 2 clocks.
module ptn_seq_gen
  import ptn_pkg::*;
#(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int FRAMES_PER_PTN = 120,
  parameter int BOX_SIZE       = 32,
  parameter bit SYNC_ACT_LOW   = 1'b1
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic [9:0] HCNT,
  input  logic [9:0] VCNT,
  input  logic       DE_IN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic       AUTO,
  input  logic [1:0] PTN_SEL,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_DE,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic [1:0] PTN_CUR
);

  localparam int             CNT_W     = (FRAMES_PER_PTN > 1) ? $clog2(FRAMES_PER_PTN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PTN - 1);
  localparam logic [9:0]     BAR_W     = 10'(H_ACTIVE / 8);
  localparam logic [9:0]     H_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]     V_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [10:0]    BOX_W     = 11'(BOX_SIZE);
  localparam logic           SYNC_IDLE = SYNC_ACT_LOW;

  logic             fs_s;
  logic [1:0]       ptn_r;
  logic [1:0]       ptn_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [9:0]       box_x_s;
  logic [9:0]       box_y_s;
  logic [9:0]       bar_q_s;
  logic [2:0]       bar_idx_s;
  logic             grid_s;
  logic             in_box_s;

  logic [1:0]  s1_ptn_r;
  logic [2:0]  s1_bar_r;
  logic        s1_grid_r;
  logic        s1_box_r;
  logic [15:0] s1_grad_r;
  logic        s1_de_r;
  logic        s1_hs_r;
  logic        s1_vs_r;
  logic [23:0] pix_s;
  logic [23:0] rgb_r;
  logic        de_r;
  logic        hs_r;
  logic        vs_r;

  assign fs_s = (HCNT == 10'd0) && (VCNT == 10'd0);

  ptn_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .PCK   (PCK),
    .RST   (RST),
    .FS    (fs_s),
    .BOX_X (box_x_s),
    .BOX_Y (box_y_s)
  );

  // Pattern selection: manual follows PTN_SEL, auto advances every FRAMES_PER_PTN frames
  always_comb begin
    ptn_nxt_s = ptn_r;
    cnt_nxt_s = cnt_r;
    if (fs_s) begin
      if (AUTO) begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = '0;
          ptn_nxt_s = ptn_r + 2'd1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          ptn_nxt_s = ptn_r;
        end
      end else begin
        cnt_nxt_s = '0;
        ptn_nxt_s = PTN_SEL;
      end
    end else begin
      ptn_nxt_s = ptn_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Frame counter and current pattern
  always_ff @(posedge PCK) begin
    if (!RST) begin
      ptn_r <= PTN_BARS;
      cnt_r <= '0;
    end else begin
      ptn_r <= ptn_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign PTN_CUR = ptn_r;

  // Per-pixel geometry flags for stage 1
  always_comb begin
    bar_q_s   = HCNT / BAR_W;
    bar_idx_s = (bar_q_s > 10'd7) ? 3'd7 : bar_q_s[2:0];
    grid_s    = (HCNT[4:0] == 5'd0) || (VCNT[4:0] == 5'd0) ||
                (HCNT == H_LAST) || (VCNT == V_LAST);
    in_box_s  = ({1'b0, HCNT} >= {1'b0, box_x_s}) && ({1'b0, HCNT} < ({1'b0, box_x_s} + BOX_W)) &&
                ({1'b0, VCNT} >= {1'b0, box_y_s}) && ({1'b0, VCNT} < ({1'b0, box_y_s} + BOX_W));
  end

  // Stage 1: pattern decode, flags and timing
  always_ff @(posedge PCK) begin
    if (!RST) begin
      s1_ptn_r  <= PTN_BARS;
      s1_bar_r  <= 3'd0;
      s1_grid_r <= 1'b0;
      s1_box_r  <= 1'b0;
      s1_grad_r <= 16'd0;
      s1_de_r   <= 1'b0;
      s1_hs_r   <= SYNC_IDLE;
      s1_vs_r   <= SYNC_IDLE;
    end else begin
      s1_ptn_r  <= ptn_nxt_s;
      s1_bar_r  <= bar_idx_s;
      s1_grid_r <= grid_s;
      s1_box_r  <= in_box_s;
      s1_grad_r <= {HCNT[9:2], VCNT[8:1]};
      s1_de_r   <= DE_IN;
      s1_hs_r   <= HSYNC_IN;
      s1_vs_r   <= VSYNC_IN;
    end
  end

  // Colour from stage-1 flags; blanking forces black
  always_comb begin
    pix_s = CLR_BLACK;
    if (s1_de_r) begin
      case (s1_ptn_r)
        PTN_BARS: pix_s = bar_color(s1_bar_r);
        PTN_GRID: pix_s = s1_grid_r ? CLR_WHITE : CLR_BLACK;
        PTN_GRAD: pix_s = {s1_grad_r, GRAD_BLUE};
        PTN_BOX:  pix_s = s1_box_r ? CLR_WHITE : CLR_BOX_BG;
        default:  pix_s = CLR_BLACK;
      endcase
    end else begin
      pix_s = CLR_BLACK;
    end
  end

  // Stage 2: RGB, DE and syncs registered together
  always_ff @(posedge PCK) begin
    if (!RST) begin
      rgb_r <= CLR_BLACK;
      de_r  <= 1'b0;
      hs_r  <= SYNC_IDLE;
      vs_r  <= SYNC_IDLE;
    end else begin
      rgb_r <= pix_s;
      de_r  <= s1_de_r;
      hs_r  <= s1_hs_r;
      vs_r  <= s1_vs_r;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_r;
  assign VGA_DE    = de_r;
  assign VGA_HSYNC = hs_r;
  assign VGA_VSYNC = vs_r;

endmodule

// File: tb/tb_ptn_seq_gen.sv
// Randomized bench for ptn_seq_gen: a frame-level reference model predicts
// pattern, box position and every output two clocks after each input.
module tb_ptn_seq_gen;

  localparam int FPP = 2;
  localparam logic [26:0] RST_VAL = {1'b0, 1'b1, 1'b1, 24'h000000};
  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic       PCK = 1'b0;
  logic       RST;
  logic [9:0] HCNT;
  logic [9:0] VCNT;
  logic       DE_IN;
  logic       HSYNC_IN;
  logic       VSYNC_IN;
  logic       AUTO;
  logic [1:0] PTN_SEL;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_DE;
  logic       VGA_HSYNC;
  logic       VGA_VSYNC;
  logic [1:0] PTN_CUR;

  int checks = 0;
  int errors = 0;

  int m_ptn, m_cnt, m_bx, m_by, m_dx, m_dy;
  bit g_auto;
  int g_sel;
  logic [26:0] exp_q[$];

  ptn_seq_gen #(
    .H_ACTIVE       (640),
    .V_ACTIVE       (480),
    .FRAMES_PER_PTN (FPP),
    .BOX_SIZE       (32),
    .SYNC_ACT_LOW   (1'b1)
  ) dut (
    .PCK       (PCK),
    .RST       (RST),
    .HCNT      (HCNT),
    .VCNT      (VCNT),
    .DE_IN     (DE_IN),
    .HSYNC_IN  (HSYNC_IN),
    .VSYNC_IN  (VSYNC_IN),
    .AUTO      (AUTO),
    .PTN_SEL   (PTN_SEL),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .VGA_DE    (VGA_DE),
    .VGA_HSYNC (VGA_HSYNC),
    .VGA_VSYNC (VGA_VSYNC),
    .PTN_CUR   (PTN_CUR)
  );

  always #5 PCK = ~PCK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_pixel(int h, int v);
    case (m_ptn)
      0:       return BAR_TAB[h / 80];
      1:       return (h % 32 == 0 || v % 32 == 0 || h == 639 || v == 479) ? 24'hFFFFFF : 24'h000000;
      2:       return {8'((h / 4) % 256), 8'((v / 2) % 256), 8'h80};
      default: return (h >= m_bx && h < m_bx + 32 && v >= m_by && v < m_by + 32) ? 24'hFFFFFF : 24'h000020;
    endcase
  endfunction

  task automatic model_reset();
    m_ptn = 0; m_cnt = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic model_fs(input bit auto_i, input int sel);
    if (auto_i) begin
      if (m_cnt == FPP - 1) begin
        m_cnt = 0;
        m_ptn = (m_ptn + 1) % 4;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
      m_ptn = sel;
    end
    if (m_dx > 0 && m_bx + 32 == 640) m_dx = -1;
    else if (m_dx < 0 && m_bx == 0)   m_dx = 1;
    else                              m_bx += m_dx;
    if (m_dy > 0 && m_by + 32 == 480) m_dy = -1;
    else if (m_dy < 0 && m_by == 0)   m_dy = 1;
    else                              m_by += m_dy;
  endtask

  // One clock: check what is due, then apply new inputs and predict their output
  task automatic step(input bit rst_i, input int h, input int v, input bit de);
    logic [26:0] e;
    bit hs, vs;
    @(negedge PCK);
    check_val("ptn_cur", 32'(PTN_CUR), 32'(m_ptn));
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check_val("pix", 32'({VGA_DE, VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B}), 32'(e));
    end
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    RST = rst_i; HCNT = 10'(h); VCNT = 10'(v); DE_IN = de;
    HSYNC_IN = hs; VSYNC_IN = vs; AUTO = g_auto; PTN_SEL = 2'(g_sel);
    if (!rst_i) begin
      model_reset();
      foreach (exp_q[i]) exp_q[i] = RST_VAL;
      exp_q.push_back(RST_VAL);
    end else begin
      if (h == 0 && v == 0) model_fs(g_auto, g_sel);
      exp_q.push_back({de, hs, vs, de ? ref_pixel(h, v) : 24'h000000});
    end
  endtask

  task automatic px(input int h, input int v);
    if (h == 0 && v == 0) h = 1;
    step(1'b1, h, v, (h < 640 && v < 480));
  endtask

  task automatic px_rand();
    px($urandom_range(0, 799), $urandom_range(0, 524));
  endtask

  task automatic fs_cycle();
    step(1'b1, 0, 0, 1'b1);
  endtask

  initial begin
    RST = 1'b0; HCNT = 10'd5; VCNT = 10'd5; DE_IN = 1'b1;
    HSYNC_IN = 1'b0; VSYNC_IN = 1'b0; AUTO = 1'b0; PTN_SEL = 2'd0;
    g_auto = 1'b0; g_sel = 0;
    model_reset();

    repeat (5) step(1'b0, $urandom_range(0, 799), $urandom_range(1, 524), 1'($urandom_range(0, 1)));

    // colour bars at bar boundaries
    for (int f = 0; f < 3; f++) begin
      fs_cycle();
      px(0, 1 + f); px(79, 7); px(80, 9); px(560, 100); px(639, 479);
      repeat (4) px_rand();
    end

    // manual change mid-frame waits for the next frame start
    fs_cycle();
    px(100, 50);
    g_sel = 2;
    px(100, 50); px_rand(); px(639, 3);
    fs_cycle();
    px(100, 50); px(639, 479); px_rand();

    // auto cycling
    g_auto = 1'b1;
    for (int f = 0; f < 20; f++) begin
      fs_cycle();
      repeat (3) px_rand();
    end

    // random mode/select changes mid-frame
    for (int f = 0; f < 30; f++) begin
      fs_cycle();
      px_rand();
      g_auto = 1'($urandom_range(0, 1));
      g_sel  = $urandom_range(0, 3);
      repeat (2) px_rand();
    end

    // box bounce across both axes, probing the box edges each frame
    g_auto = 1'b0; g_sel = 3;
    for (int f = 0; f < 1000; f++) begin
      fs_cycle();
      px((m_bx > 0) ? m_bx - 1 : 0, m_by);
      px(m_bx, m_by);
      px(m_bx + 31, m_by + 31);
      px(m_bx + 32, m_by + 31);
      px(m_bx + 5, m_by + 32);
      if (f % 8 == 0) px_rand();
    end

    // grid with plenty of blanking
    g_sel = 1;
    for (int f = 0; f < 20; f++) begin
      fs_cycle();
      px(32, 100); px(639, 200); px(33, 479);
      repeat (4) px_rand();
    end

    // reset mid-frame then recovery
    fs_cycle();
    px(200, 200); px_rand();
    repeat (3) step(1'b0, $urandom_range(0, 799), $urandom_range(1, 524), 1'($urandom_range(0, 1)));
    g_auto = 1'b1;
    for (int f = 0; f < 6; f++) begin
      px_rand();
      fs_cycle();
      repeat (3) px_rand();
    end

    repeat (3) px_rand();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
